// File: rtl/spi_sample_input.sv
// SPI mode-0 slave that receives 24-bit channel/sample frames and returns
// offset-corrected 32-bit left/right sample pairs in the core clock domain.
module spi_sample_input #(
  parameter logic [31:0] SAMPLE_OFFSET  = 32'h0002_1000,
  parameter logic [7:0]  RECV_CHANNEL_A = 8'b0011_0001,
  parameter logic [7:0]  RECV_CHANNEL_B = 8'b0011_0010
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SPI_CS,
  input  logic        i_SPI_clock,
  input  logic        i_SPI_data,
  output logic [31:0] o_Sample_L,
  output logic [31:0] o_Sample_R,
  output logic        o_Sample_Valid,
  output logic        o_Frame_Error,
  output logic        o_Busy
);

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    sm_idle  = 2'd0,
    sm_shift = 2'd1,
    sm_check = 2'd2
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_cs_sync;
  logic [2:0]              r_sck_sync;
  logic [1:0]              r_data_sync;
  logic [FRAME_BITS-1:0]   r_sr;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_l_pending;
  logic [31:0]             r_l_hold;
  logic [31:0]             r_sample_l;
  logic [31:0]             r_sample_r;
  logic                    r_valid;
  logic                    r_error;
  logic                    r_busy;

  logic                    w_cs_fall;
  logic                    w_cs_rise;
  logic                    w_sck_rise;
  logic [7:0]              w_cmd;
  logic                    w_len_ok;
  logic                    w_is_a;
  logic                    w_is_b;
  logic [31:0]             w_value;

  // Edge detection on the synchronised CS and SCK (stage 2 vs stage 1).
  assign w_cs_fall  =  r_cs_sync[2]  & ~r_cs_sync[1];
  assign w_cs_rise  = ~r_cs_sync[2]  &  r_cs_sync[1];
  assign w_sck_rise = ~r_sck_sync[2] &  r_sck_sync[1];

  assign w_cmd    = r_sr[23:16];
  assign w_len_ok = (r_bit_cnt == CNT_W'(FRAME_BITS));
  assign w_is_a   = w_len_ok && (w_cmd == RECV_CHANNEL_A);
  assign w_is_b   = w_len_ok && (w_cmd == RECV_CHANNEL_B);
  assign w_value  = {14'd0, r_sr[15:0], 2'b00} - SAMPLE_OFFSET;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_cs_sync   <= 3'b000;
      r_sck_sync  <= 3'b000;
      r_data_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], i_SPI_CS};
      r_sck_sync  <= {r_sck_sync[1:0], i_SPI_clock};
      r_data_sync <= {r_data_sync[0], i_SPI_data};
    end
  end

  // Frame FSM with shift register, pairing logic and registered outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= sm_idle;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_l_pending <= 1'b0;
      r_l_hold    <= '0;
      r_sample_l  <= '0;
      r_sample_r  <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        sm_idle: begin
          if (w_cs_fall) begin
            r_state   <= sm_shift;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        sm_shift: begin
          if (w_cs_rise) begin
            r_state <= sm_check;
            r_busy  <= 1'b0;
          end else if (w_sck_rise) begin
            r_sr <= {r_sr[FRAME_BITS-2:0], r_data_sync[1]};
            if (r_bit_cnt != {CNT_W{1'b1}}) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        sm_check: begin
          if (w_is_a) begin
            r_l_hold    <= w_value;
            r_l_pending <= 1'b1;
          end else if (w_is_b && r_l_pending) begin
            r_sample_l  <= r_l_hold;
            r_sample_r  <= w_value;
            r_valid     <= 1'b1;
            r_l_pending <= 1'b0;
          end else begin
            r_error <= 1'b1;
          end
          // A CS fall that lands here would otherwise be lost as a one-cycle pulse.
          if (w_cs_fall) begin
            r_state   <= sm_shift;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end else begin
            r_state <= sm_idle;
          end
        end
        default: begin
          r_state <= sm_idle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Sample_L     = r_sample_l;
  assign o_Sample_R     = r_sample_r;
  assign o_Sample_Valid = r_valid;
  assign o_Frame_Error  = r_error;
  assign o_Busy         = r_busy;

endmodule

// File: tb/tb_spi_sample_input.sv
// Scoreboard bench for spi_sample_input: directed frames push expected
// pulses into a queue, a monitor pops and compares on every output pulse.
`timescale 1ns/100ps
module tb_spi_sample_input;

  localparam int RAND_PAIRS = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        sck;
  logic        sdi;
  logic [31:0] o_l;
  logic [31:0] o_r;
  logic        o_valid;
  logic        o_err;
  logic        o_busy;

  typedef struct {
    bit          is_err;
    logic [31:0] l;
    logic [31:0] r;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  int          checks   = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  logic        cs_prev  = 1'b1;
  logic [31:0] cur_l    = '0;
  logic [31:0] cur_r    = '0;

  spi_sample_input dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_SPI_CS       (cs),
    .i_SPI_clock    (sck),
    .i_SPI_data     (sdi),
    .o_Sample_L     (o_l),
    .o_Sample_R     (o_r),
    .o_Sample_Valid (o_valid),
    .o_Frame_Error  (o_err),
    .o_Busy         (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] decode(input logic [15:0] s);
    return {14'd0, s, 2'b00} - 32'h0002_1000;
  endfunction

  // Edge 1 is the first clock edge that samples CS high.
  always @(posedge clk) begin
    if (!cs_prev && cs) edge_cnt = 1;
    else edge_cnt = edge_cnt + 1;
    cs_prev = cs;
  end

  always @(negedge clk) begin
    if (!rst && (o_valid || o_err)) begin
      if (o_valid && o_err) begin
        check("valid_err_overlap", 32'(o_err), 32'(0));
      end else if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual valid=%0b err=%0b required=no pulse", o_valid, o_err);
      end else begin
        m_e = q.pop_front();
        check("pulse_kind_err", 32'(o_err), 32'(m_e.is_err));
        check("sample_l", o_l, m_e.l);
        check("sample_r", o_r, m_e.r);
        check("pulse_latency", 32'(edge_cnt), 32'(4));
      end
    end
  end

  task automatic sck_bit(input logic b);
    sdi = b;
    #30 sck = 1'b1;
    #30 sck = 1'b0;
  endtask

  task automatic send_raw(input logic [31:0] bits, input int n);
    cs = 1'b0;
    #30;
    for (int i = n - 1; i >= 0; i--) begin
      sck_bit(bits[i]);
      if (i == n / 2) check("busy_mid_frame", 32'(o_busy), 32'(1));
    end
    #30 cs = 1'b1;
    #60;
    check("busy_after_frame", 32'(o_busy), 32'(0));
  endtask

  task automatic send_a(input logic [15:0] s);
    send_raw({8'h00, 8'h31, s}, 24);
  endtask

  task automatic send_b(input logic [15:0] s, input logic [31:0] el, input logic [31:0] er);
    q.push_back('{1'b0, el, er});
    cur_l = el;
    cur_r = er;
    send_raw({8'h00, 8'h32, s}, 24);
  endtask

  task automatic send_err(input logic [31:0] bits, input int n);
    q.push_back('{1'b1, cur_l, cur_r});
    send_raw(bits, n);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s1;
    logic [15:0] s2;
    rst = 1'b1;
    cs  = 1'b1;
    sck = 1'b0;
    sdi = 1'b0;
    #0.3;
    #20;
    check("reset_l", o_l, 32'h0);
    check("reset_r", o_r, 32'h0);
    check("reset_valid", 32'(o_valid), 32'(0));
    check("reset_err", 32'(o_err), 32'(0));
    check("reset_busy", 32'(o_busy), 32'(0));
    rst = 1'b0;
    #40;

    // Basic pair decode and wrap-around.
    send_a(16'h8400);
    send_b(16'hC000, 32'h0000_0000, 32'h0000_F000);
    send_a(16'h0000);
    send_b(16'hFFFF, 32'hFFFD_F000, 32'h0001_EFFC);

    // Rejected frames: short, long, bad command, B without A.
    send_err({9'h000, 23'h31_8400 >> 1}, 23);
    send_err({7'h00, 1'b1, 8'h31, 16'h8400}, 25);
    send_err({8'h00, 8'h33, 16'h8400}, 24);
    send_err({8'h00, 8'h32, 16'h8400}, 24);

    // Second A overwrites the held left sample.
    send_a(16'h1000);
    send_a(16'h9000);
    send_b(16'h8400, 32'h0000_3000, 32'h0000_0000);

    // Async reset in the middle of a frame with a left sample pending.
    send_a(16'h4000);
    cs = 1'b0;
    #30;
    for (int i = 0; i < 12; i++) sck_bit(1'b1);
    rst = 1'b1;
    #1;
    check("midreset_l", o_l, 32'h0);
    check("midreset_r", o_r, 32'h0);
    check("midreset_valid", 32'(o_valid), 32'(0));
    check("midreset_err", 32'(o_err), 32'(0));
    check("midreset_busy", 32'(o_busy), 32'(0));
    cur_l = '0;
    cur_r = '0;
    #20 rst = 1'b0;
    for (int i = 0; i < 12; i++) sck_bit(1'b0);
    #30 cs = 1'b1;
    #60;
    send_err({8'h00, 8'h32, 16'hC000}, 24);

    // Minimum SCK phases with random frame phase against the core clock.
    for (int k = 0; k < RAND_PAIRS; k++) begin
      s1 = 16'($urandom);
      s2 = 16'($urandom);
      #($urandom_range(0, 9));
      send_a(s1);
      #($urandom_range(0, 9));
      send_b(s2, decode(s1), decode(s2));
    end

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
